// File: rtl/joystick_pkg.sv
// Shared joystick constants: default DRP addresses, scheduler FSM states,
// ADC sample width and the LED/maze deflection thresholds.
package joystick_pkg;

  localparam int ADC_WIDTH = 12;

  localparam logic [6:0] DEF_X_ADDR = 7'h16;
  localparam logic [6:0] DEF_Y_ADDR = 7'h1E;

  // Deflection thresholds shared by joystick_led_controller and the maze FSM
  localparam logic [ADC_WIDTH-1:0] LOW_THRESHOLD  = 12'h400;
  localparam logic [ADC_WIDTH-1:0] HIGH_THRESHOLD = 12'hC00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_X   = 3'd1,
    WAIT_X  = 3'd2,
    REQ_Y   = 3'd3,
    WAIT_Y  = 3'd4,
    PUBLISH = 3'd5
  } sched_state_t;

endpackage

// File: rtl/tick_generator.sv
// Emits a one-cycle tick every INPUT_FREQ/TICK_HZ clock cycles.
module tick_generator #(
  parameter int INPUT_FREQ = 100_000_000,
  parameter int TICK_HZ    = 1_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PERIOD = (INPUT_FREQ / TICK_HZ < 2) ? 2 : INPUT_FREQ / TICK_HZ;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(PERIOD - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/xadc_joystick_scheduler.sv
// Paced, timeout-guarded X-then-Y XADC DRP reader publishing coherent pairs.
// Define JOYSTICK_AVG_EN to publish the mean of every 4 pairs instead of raw pairs.
module xadc_joystick_scheduler
  import joystick_pkg::*;
#(
  parameter int         INPUT_FREQ     = 100_000_000,
  parameter int         SAMPLE_HZ      = 1_000,
  parameter logic [6:0] X_ADDR         = DEF_X_ADDR,
  parameter logic [6:0] Y_ADDR         = DEF_Y_ADDR,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [6:0]           daddr,
  output logic                 den,
  output logic                 dwe,
  output logic [15:0]          di,
  input  logic [15:0]          do_data,
  input  logic                 drdy,
  output logic [ADC_WIDTH-1:0] adc_x_value,
  output logic [ADC_WIDTH-1:0] adc_y_value,
  output logic                 sample_valid,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t         state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [ADC_WIDTH-1:0] x_shadow;
  logic [ADC_WIDTH-1:0] y_shadow;
  logic                 start;
  logic                 unused_low_nibble;

  assign dwe = 1'b0;
  assign di  = 16'h0000;
  assign unused_low_nibble = ^do_data[3:0];

  tick_generator #(
    .INPUT_FREQ(INPUT_FREQ),
    .TICK_HZ   (SAMPLE_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (start)
  );

`ifdef JOYSTICK_AVG_EN
  logic [13:0] acc_x;
  logic [13:0] acc_y;
  logic [1:0]  pair_cnt;
  logic [13:0] sum_x;
  logic [13:0] sum_y;

  assign sum_x = acc_x + {2'b00, x_shadow};
  assign sum_y = acc_y + {2'b00, y_shadow};
`endif

  // A timed-out wait abandons the sequence; a tick outside IDLE is dropped and flagged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      daddr        <= X_ADDR;
      den          <= 1'b0;
      wait_cnt     <= '0;
      x_shadow     <= '0;
      y_shadow     <= '0;
      adc_x_value  <= '0;
      adc_y_value  <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
`ifdef JOYSTICK_AVG_EN
      acc_x        <= '0;
      acc_y        <= '0;
      pair_cnt     <= '0;
`endif
    end else begin
      den          <= 1'b0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state <= REQ_X;
            daddr <= X_ADDR;
            den   <= 1'b1;
          end
        end
        REQ_X: begin
          state    <= WAIT_X;
          wait_cnt <= '0;
        end
        WAIT_X: begin
          if (drdy) begin
            x_shadow <= do_data[15:4];
            state    <= REQ_Y;
            daddr    <= Y_ADDR;
            den      <= 1'b1;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
`ifdef JOYSTICK_AVG_EN
            acc_x    <= '0;
            acc_y    <= '0;
            pair_cnt <= '0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        REQ_Y: begin
          state    <= WAIT_Y;
          wait_cnt <= '0;
        end
        WAIT_Y: begin
          if (drdy) begin
            y_shadow <= do_data[15:4];
            state    <= PUBLISH;
          end else if (wait_cnt == LAST_WAIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
`ifdef JOYSTICK_AVG_EN
            acc_x    <= '0;
            acc_y    <= '0;
            pair_cnt <= '0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        PUBLISH: begin
          state <= IDLE;
`ifdef JOYSTICK_AVG_EN
          if (pair_cnt == 2'd3) begin
            adc_x_value  <= sum_x[13:2];
            adc_y_value  <= sum_y[13:2];
            sample_valid <= 1'b1;
            acc_x        <= '0;
            acc_y        <= '0;
          end else begin
            acc_x <= sum_x;
            acc_y <= sum_y;
          end
          pair_cnt <= pair_cnt + 1'b1;
`else
          adc_x_value  <= x_shadow;
          adc_y_value  <= y_shadow;
          sample_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_joystick_scheduler.sv
// Randomized bench for xadc_joystick_scheduler with a pair-level reference model.
module tb_xadc_joystick_scheduler;

  localparam int         INPUT_FREQ = 100_000;
  localparam int         SAMPLE_HZ  = 500;
  localparam logic [6:0] X_ADDR     = 7'h16;
  localparam logic [6:0] Y_ADDR     = 7'h1E;
  localparam int         TIMEOUT    = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic [15:0] do_data = 16'h0000;
  logic        drdy = 1'b0;
  logic [11:0] adc_x_value, adc_y_value;
  logic        sample_valid, timeout_err, overrun;

  int check_count = 0;
  int pass_count  = 0;

  int exp_x = 0, exp_y = 0, exp_pub = 0;
  int sum_x = 0, sum_y = 0, pairs = 0;

  xadc_joystick_scheduler #(
    .INPUT_FREQ    (INPUT_FREQ),
    .SAMPLE_HZ     (SAMPLE_HZ),
    .X_ADDR        (X_ADDR),
    .Y_ADDR        (Y_ADDR),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .daddr       (daddr),
    .den         (den),
    .dwe         (dwe),
    .di          (di),
    .do_data     (do_data),
    .drdy        (drdy),
    .adc_x_value (adc_x_value),
    .adc_y_value (adc_y_value),
    .sample_valid(sample_valid),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pair-level model: raw publish, or mean of every four pairs when averaging
  task automatic model_pair(input int x, input int y);
`ifdef JOYSTICK_AVG_EN
    sum_x += x;
    sum_y += y;
    pairs++;
    if (pairs == 4) begin
      exp_x = sum_x / 4;
      exp_y = sum_y / 4;
      exp_pub = 1;
      sum_x = 0; sum_y = 0; pairs = 0;
    end else begin
      exp_pub = 0;
    end
`else
    exp_x = x;
    exp_y = y;
    exp_pub = 1;
`endif
  endtask

  task automatic model_clear_avg();
    sum_x = 0; sum_y = 0; pairs = 0;
  endtask

  task automatic wait_den(output bit found);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (den) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("den_wait_timeout", 32'd0, 32'd1);
  endtask

  // One full X-then-Y transaction with per-axis drdy latency
  task automatic applyStimulus(input logic [15:0] xd, input logic [15:0] yd, input int lx, input int ly);
    bit found;
    wait_den(found);
    if (!found) return;
    checkOutput("daddr_x", daddr, X_ADDR);
    for (int i = 0; i < lx; i++) step();
    drdy = 1'b1; do_data = xd;
    step();
    drdy = 1'b0; do_data = 16'($urandom);
    checkOutput("den_y", den, 1);
    checkOutput("daddr_y", daddr, Y_ADDR);
    for (int i = 0; i < ly; i++) step();
    drdy = 1'b1; do_data = yd;
    step();
    drdy = 1'b0; do_data = 16'($urandom);
    checkOutput("sample_valid_early", sample_valid, 0);
    step();
    model_pair(int'(xd[15:4]), int'(yd[15:4]));
    checkOutput("sample_valid", sample_valid, exp_pub);
    checkOutput("adc_x_value", adc_x_value, exp_x);
    checkOutput("adc_y_value", adc_y_value, exp_y);
  endtask

  initial begin
    bit found;
    bit saw_valid;
    logic [15:0] xd, yd;

    reset = 1'b0;
    repeat (3) step();
    checkOutput("reset_daddr", daddr, X_ADDR);
    checkOutput("reset_den", den, 0);
    checkOutput("reset_adc_x", adc_x_value, 0);
    checkOutput("reset_adc_y", adc_y_value, 0);
    checkOutput("reset_flags", {sample_valid, timeout_err, overrun}, 0);
    checkOutput("dwe_di_tied", {dwe, di}, 0);
    reset = 1'b1;

    applyStimulus(16'd100 << 4, 16'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));
    applyStimulus(16'd101 << 4, 16'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));
    applyStimulus(16'd102 << 4, 16'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));
    applyStimulus(16'd104 << 4, 16'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));

    applyStimulus(16'hC810, 16'h0FF0, 3, 3);
    for (int n = 0; n < 7; n++) begin
      xd = 16'($urandom);
      yd = 16'($urandom);
      applyStimulus(xd, yd, $urandom_range(1, 8), $urandom_range(1, 8));
    end
    checkOutput("overrun_clear", overrun, 0);

    step();
    drdy = 1'b1; do_data = 16'hABCD;
    step();
    drdy = 1'b0;
    repeat (3) step();
    checkOutput("idle_drdy_valid", sample_valid, 0);
    checkOutput("idle_drdy_x", adc_x_value, exp_x);
    checkOutput("idle_drdy_y", adc_y_value, exp_y);

    wait_den(found);
    if (found) begin
      checkOutput("timeout_daddr", daddr, X_ADDR);
      for (int i = 0; i < TIMEOUT; i++) step();
      checkOutput("timeout_not_yet", timeout_err, 0);
      step();
      checkOutput("timeout_err", timeout_err, 1);
      checkOutput("timeout_no_valid", sample_valid, 0);
      checkOutput("timeout_x_kept", adc_x_value, exp_x);
      checkOutput("timeout_y_kept", adc_y_value, exp_y);
      step();
      checkOutput("timeout_pulse_end", timeout_err, 0);
      model_clear_avg();
    end
    checkOutput("overrun_set", overrun, 1);

    for (int n = 0; n < 4; n++) begin
      xd = 16'($urandom);
      yd = 16'($urandom);
      applyStimulus(xd, yd, $urandom_range(1, 8), $urandom_range(1, 8));
    end
    checkOutput("overrun_sticky", overrun, 1);

    wait_den(found);
    if (found) begin
      step(); step();
      drdy = 1'b1; do_data = 16'h5550;
      step();
      drdy = 1'b0;
      step(); step();
      reset = 1'b0;
      #1;
      checkOutput("midseq_reset_daddr", daddr, X_ADDR);
      checkOutput("midseq_reset_den", den, 0);
      checkOutput("midseq_reset_x", adc_x_value, 0);
      checkOutput("midseq_reset_y", adc_y_value, 0);
      checkOutput("midseq_reset_flags", {sample_valid, timeout_err, overrun}, 0);
      exp_x = 0; exp_y = 0;
      model_clear_avg();
      step(); step();
      reset = 1'b1;
      saw_valid = 1'b0;
      step();
      drdy = 1'b1; do_data = 16'h1230;
      step();
      drdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (sample_valid) saw_valid = 1'b1;
      end
      checkOutput("stray_drdy_valid", saw_valid, 0);
      checkOutput("stray_drdy_x", adc_x_value, 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/xadc_joystick_scheduler.md
# xadc_joystick_scheduler

Sequences XADC Dynamic Reconfiguration Port (DRP) reads for the two joystick axes and publishes one coherent 12-bit X/Y pair per sample period. It sits between the XADC primitive and `joystick_led_controller` and the maze FSM, replacing free-running channel polling with a paced, timeout-guarded X-then-Y read sequence.

## Interface
Parameters:
- `INPUT_FREQ`, 100_000_000: clock frequency in Hz.
- `SAMPLE_HZ`, 1_000: rate at which X/Y read sequences start.
- `X_ADDR`, 7'h16: DRP status address of the X axis (VAUX6).
- `Y_ADDR`, 7'h1E: DRP status address of the Y axis (VAUX14).
- `TIMEOUT_CYCLES`, 255: maximum wait for `drdy` after a `den` pulse.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset.
- `daddr` out 7: DRP address.
- `den` out 1: DRP enable, one-cycle pulse.
- `dwe` out 1: DRP write enable, tied 0.
- `di` out 16: DRP write data, tied 0.
- `do_data` in 16: DRP read data.
- `drdy` in 1: DRP read-data valid.
- `adc_x_value` out 12: latest published X sample.
- `adc_y_value` out 12: latest published Y sample.
- `sample_valid` out 1: one-cycle pulse when a new pair is published.
- `timeout_err` out 1: one-cycle pulse when a read is abandoned.
- `overrun` out 1: sticky flag; a start tick arrived while the sequence was busy.

## Operation
- The internal `tick_generator` emits `start` at `SAMPLE_HZ`.
- FSM states: IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, PUBLISH.
- IDLE: when `start` is high, go to REQ_X.
- REQ_X: drive `daddr=X_ADDR` and `den=1` for exactly one cycle, then go to WAIT_X.
- WAIT_X: when `drdy` is high, capture `do_data[15:4]` into the X shadow register and go to REQ_Y.
- REQ_Y and WAIT_Y: same as REQ_X and WAIT_X, using `Y_ADDR` and the Y shadow register. WAIT_Y exits to PUBLISH.
- PUBLISH: copy both shadows to `adc_x_value` and `adc_y_value` together, pulse `sample_valid`, and return to IDLE.
- Timeout:
  - The wait counter is cleared on entry to WAIT_x and increments each cycle `drdy` is low.
  - When it reaches `TIMEOUT_CYCLES`, pulse `timeout_err` and return to IDLE.
  - Outputs keep their previous values, and no `sample_valid` is issued.
- `drdy` in any state other than WAIT_x is ignored.
- A `start` in any non-IDLE state is dropped and sets `overrun`. Only reset clears `overrun`.
- `daddr` holds the last requested address between requests. `dwe` and `di` are always 0.

## Timing
- Reset values: `daddr=X_ADDR`, `den=0`, `adc_x_value=0`, `adc_y_value=0`, `sample_valid=0`, `timeout_err=0`, `overrun=0`, state IDLE.
- Reset asserted mid-sequence forces IDLE immediately. Any later `drdy` is ignored.
- `den` asserts the cycle after `start` is seen.
- `drdy` is accepted no earlier than the cycle after `den`.
- Data is captured on the `drdy` cycle, and the next `den` follows one cycle later.
- `sample_valid` and the updated outputs become visible together, one cycle after the Y capture.
- With XADC `drdy` latency L, end-to-end latency from `start` to `sample_valid` is 2L+4 cycles.

## Configuration
- `JOYSTICK_AVG_EN` defined:
  - Each axis keeps a 14-bit accumulator that sums 4 consecutive captured samples.
  - PUBLISH fires only on every 4th completed pair and outputs `sum[13:2]` (truncating), then clears the accumulators.
  - A timeout clears both accumulators and the pair count.
- `JOYSTICK_AVG_EN` undefined: every completed pair is published raw, and no accumulator logic exists.

## Structure
- A shared `joystick_pkg` (Verilog header) holds:
  - the default DRP addresses;
  - the FSM state encodings;
  - the 12-bit ADC width constant;
  - the threshold constants already used by the LED and maze logic.
- One sub-module: the existing `tick_generator`, instantiated with `INPUT_FREQ` and `TICK_HZ=SAMPLE_HZ`. No other hierarchy.

## Test plan
- Reset low mid-WAIT_Y, then released -> all outputs at their reset values, and a stray `drdy` produces no `sample_valid`.
- Start; DRP model returns 16'hC810 (X), then 16'h0FF0 (Y) with L=3 -> `adc_x_value=12'hC81`, `adc_y_value=12'h0FF`, `sample_valid` pulses 10 cycles after `start`.
- X read: `drdy` never asserts -> `timeout_err` pulses 255 cycles into WAIT_X, outputs unchanged, FSM back in IDLE.
- Second `start` forced while in WAIT_X -> `overrun=1` and stays set after later samples complete.
- `JOYSTICK_AVG_EN` with X samples 100, 101, 102, 104 -> one `sample_valid` after the 4th pair with `adc_x_value=101`.
- `drdy` pulsed while in IDLE -> no capture, no output change.
